// File: rtl/calc_n_core.sv
// rtl/calc_n_core.sv - multi-port tagged calculator core
// Per-port capture FSM and request FIFO, round-robin arbiter, shared ALU with registered output.
module calc_n_core #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 2,
   parameter int QDEPTH    = 4
) (
   input  logic                          c_clk,
   input  logic                          reset,
   input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
   input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
   input  logic [TAG_W*NUM_PORTS-1:0]    req_tag_in,
   output logic [NUM_PORTS-1:0]          req_ready,
   output logic [2*NUM_PORTS-1:0]        out_resp,
   output logic [DATA_W*NUM_PORTS-1:0]   out_data,
   output logic [TAG_W*NUM_PORTS-1:0]    out_tag
);
   localparam int SHW = $clog2(DATA_W);
   localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int QW  = $clog2(QDEPTH);

   typedef enum logic [1:0] {S_IDLE, S_OP2, S_DISCARD} cap_state_t;

   logic [NUM_PORTS-1:0] fifo_nonempty;
   logic [NUM_PORTS-1:0] pop;
   logic [3:0]           head_cmd [NUM_PORTS];
   logic [DATA_W-1:0]    head_op1 [NUM_PORTS];
   logic [DATA_W-1:0]    head_op2 [NUM_PORTS];
   logic [TAG_W-1:0]     head_tag [NUM_PORTS];

   logic          gnt_valid;
   logic [PW-1:0] gnt_port;
   logic [PW-1:0] rr_ptr;
   int            idx;

   logic               out_v;
   logic [PW-1:0]      out_port;
   logic [1:0]         res_resp;
   logic [DATA_W-1:0]  res_data;
   logic [TAG_W-1:0]   res_tag;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      cap_state_t          state, state_nxt;
      logic [3:0]          cmd_in;
      logic [DATA_W-1:0]   data_in;
      logic [TAG_W-1:0]    tag_in;
      logic [3:0]          cmd_l;
      logic [DATA_W-1:0]   op1_l;
      logic [TAG_W-1:0]    tag_l;
      logic [3:0]          q_cmd [QDEPTH];
      logic [DATA_W-1:0]   q_op1 [QDEPTH];
      logic [DATA_W-1:0]   q_op2 [QDEPTH];
      logic [TAG_W-1:0]    q_tag [QDEPTH];
      logic [QW-1:0]       wr_ptr, rd_ptr;
      logic [QW:0]         count;
      logic [QW+1:0]       occ;
      logic                wr;
      logic                accept;

      assign cmd_in  = req_cmd_in[4*p +: 4];
      assign data_in = req_data_in[DATA_W*p +: DATA_W];
      assign tag_in  = req_tag_in[TAG_W*p +: TAG_W];

      // An entry held in OP2 already owns a FIFO slot for admission purposes.
      assign wr           = (state == S_OP2);
      assign occ          = {1'b0, count} + {{(QW+1){1'b0}}, wr};
      assign req_ready[p] = (state == S_IDLE) && (occ < (QW+2)'(QDEPTH));
      assign accept       = req_ready[p] && (cmd_in != 4'd0);

      always_comb begin
         state_nxt = state;
         case (state)
            S_IDLE:    if (cmd_in != 4'd0) state_nxt = req_ready[p] ? S_OP2 : S_DISCARD;
            S_OP2:     state_nxt = S_IDLE;
            S_DISCARD: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge c_clk or negedge reset) begin
         if (!reset) begin
            state  <= S_IDLE;
            cmd_l  <= '0;
            op1_l  <= '0;
            tag_l  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            state <= state_nxt;
            if (accept) begin
               cmd_l <= cmd_in;
               op1_l <= data_in;
               tag_l <= tag_in;
            end
            if (wr) wr_ptr <= wr_ptr + QW'(1);
            if (pop[p]) rd_ptr <= rd_ptr + QW'(1);
            case ({wr, pop[p]})
               2'b10:   count <= count + (QW+1)'(1);
               2'b01:   count <= count - (QW+1)'(1);
               default: count <= count;
            endcase
         end
      end

      always_ff @(posedge c_clk) begin
         if (wr) begin
            q_cmd[wr_ptr] <= cmd_l;
            q_op1[wr_ptr] <= op1_l;
            q_op2[wr_ptr] <= data_in;
            q_tag[wr_ptr] <= tag_l;
         end
      end

      assign fifo_nonempty[p] = (count != '0);
      assign head_cmd[p]      = q_cmd[rd_ptr];
      assign head_op1[p]      = q_op1[rd_ptr];
      assign head_op2[p]      = q_op2[rd_ptr];
      assign head_tag[p]      = q_tag[rd_ptr];
      assign pop[p]           = gnt_valid && (gnt_port == PW'(p));

      assign out_resp[2*p +: 2]          = (out_v && out_port == PW'(p)) ? res_resp : 2'd0;
      assign out_data[DATA_W*p +: DATA_W] = (out_v && out_port == PW'(p)) ? res_data : '0;
      assign out_tag[TAG_W*p +: TAG_W]    = (out_v && out_port == PW'(p)) ? res_tag : '0;
   end

   always_comb begin
      gnt_valid = 1'b0;
      gnt_port  = '0;
      idx       = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!gnt_valid && fifo_nonempty[idx]) begin
            gnt_valid = 1'b1;
            gnt_port  = idx[PW-1:0];
         end
      end
   end

   logic [3:0]        sel_cmd;
   logic [DATA_W-1:0] sel_op1, sel_op2;
   logic [DATA_W:0]   sum_w;
   logic [1:0]        alu_resp;
   logic [DATA_W-1:0] alu_data;

   assign sel_cmd = head_cmd[gnt_port];
   assign sel_op1 = head_op1[gnt_port];
   assign sel_op2 = head_op2[gnt_port];
   assign sum_w   = {1'b0, sel_op1} + {1'b0, sel_op2};

   always_comb begin
      alu_resp = 2'd2;
      alu_data = '0;
      case (sel_cmd)
         4'd1: if (!sum_w[DATA_W]) begin alu_resp = 2'd1; alu_data = sum_w[DATA_W-1:0]; end
         4'd2: if (sel_op2 <= sel_op1) begin alu_resp = 2'd1; alu_data = sel_op1 - sel_op2; end
         4'd5: begin alu_resp = 2'd1; alu_data = sel_op1 << sel_op2[SHW-1:0]; end
         4'd6: begin alu_resp = 2'd1; alu_data = sel_op1 >> sel_op2[SHW-1:0]; end
         default: ;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         out_v    <= 1'b0;
         out_port <= '0;
         res_resp <= '0;
         res_data <= '0;
         res_tag  <= '0;
      end else begin
         out_v <= gnt_valid;
         if (gnt_valid) begin
            rr_ptr   <= (gnt_port == PW'(NUM_PORTS-1)) ? '0 : gnt_port + PW'(1);
            out_port <= gnt_port;
            res_resp <= alu_resp;
            res_data <= alu_data;
            res_tag  <= head_tag[gnt_port];
         end
      end
   end
endmodule

// File: tb/tb_calc_n_core.sv
// tb/tb_calc_n_core.sv - directed vector bench for calc_n_core
// Table vectors for single requests plus sequences for contention, backpressure and reset.
module tb_calc_n_core;
   localparam int NP = 4;
   localparam int DW = 32;
   localparam int TW = 2;

   logic              c_clk = 1'b0;
   logic              reset;
   logic [4*NP-1:0]   req_cmd_in;
   logic [DW*NP-1:0]  req_data_in;
   logic [TW*NP-1:0]  req_tag_in;
   logic [NP-1:0]     req_ready;
   logic [2*NP-1:0]   out_resp;
   logic [DW*NP-1:0]  out_data;
   logic [TW*NP-1:0]  out_tag;

   calc_n_core #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .QDEPTH(4)) dut (
      .c_clk(c_clk), .reset(reset),
      .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
      .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 c_clk = ~c_clk;

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  tag;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [1:0]  tag;
      logic [31:0] data;
   } exp_t;

   vec_t vecs [11];
   exp_t expq [NP][$];
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_cmd_in  = '0;
      req_data_in = '0;
      req_tag_in  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (3) @(posedge c_clk);
      #1 reset = 1'b1;
   endtask

   task automatic check_all_idle(input string name);
      chk({name, "_resp"}, 128'(out_resp), 128'd0);
      chk({name, "_data"}, 128'(out_data), 128'd0);
      chk({name, "_tag"}, 128'(out_tag), 128'd0);
   endtask

   initial begin
      vec_t       v;
      logic [1:0] phase;
      int         seq;
      int         rej_cnt;
      logic [NP-1:0]  pend;
      logic [NP-1:0]  acc;
      logic [31:0]    pend_op1 [NP];
      logic [1:0]     pend_tag [NP];
      logic [1:0]     r;
      exp_t           e;

      vecs[0]  = '{1, 4'd1, 32'h30,       32'h20, 2'd1, 2'd1, 32'h50};
      vecs[1]  = '{0, 4'd1, 32'hFFFFFFFF, 32'h1,  2'd0, 2'd2, 32'h0};
      vecs[2]  = '{0, 4'd2, 32'h10,       32'h20, 2'd2, 2'd2, 32'h0};
      vecs[3]  = '{0, 4'd3, 32'h5,        32'h6,  2'd3, 2'd2, 32'h0};
      vecs[4]  = '{0, 4'd2, 32'h20,       32'h10, 2'd1, 2'd1, 32'h10};
      vecs[5]  = '{2, 4'd5, 32'h1,        32'h24, 2'd2, 2'd1, 32'h10};
      vecs[6]  = '{3, 4'd6, 32'h80000000, 32'd31, 2'd3, 2'd1, 32'h1};
      vecs[7]  = '{1, 4'd6, 32'hF0,       32'h4,  2'd0, 2'd1, 32'hF};
      vecs[8]  = '{2, 4'd1, 32'h7FFFFFFF, 32'h1,  2'd1, 2'd1, 32'h80000000};
      vecs[9]  = '{3, 4'd15, 32'h9,       32'h1,  2'd2, 2'd2, 32'h0};
      vecs[10] = '{0, 4'd2, 32'h5,        32'h5,  2'd3, 2'd1, 32'h0};

      do_reset();
      @(negedge c_clk);
      check_all_idle("reset");
      chk("reset_ready", 128'(req_ready), 128'hF);

      // Single requests: response exactly three cycles after cycle A, one cycle wide.
      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         tick();
         chk("vec_ready_A", 128'(req_ready[v.port]), 128'd1);
         req_cmd_in[4*v.port +: 4]   = v.cmd;
         req_data_in[DW*v.port +: DW] = v.op1;
         req_tag_in[TW*v.port +: TW]  = v.tag;
         tick();
         req_cmd_in[4*v.port +: 4]   = 4'd0;
         req_data_in[DW*v.port +: DW] = v.op2;
         req_tag_in[TW*v.port +: TW]  = 2'd0;
         tick();
         clear_inputs();
         @(negedge c_clk);
         chk("vec_early", 128'(out_resp), 128'd0);
         tick();
         @(negedge c_clk);
         chk("vec_resp", 128'(out_resp), 128'(v.resp) << (2*v.port));
         chk("vec_data", 128'(out_data), 128'(v.data) << (DW*v.port));
         chk("vec_tag", 128'(out_tag), 128'(v.tag) << (TW*v.port));
         tick();
         @(negedge c_clk);
         chk("vec_late", 128'(out_resp), 128'd0);
      end

      // All four ports in the same cycle A: responses in port order on consecutive cycles.
      do_reset();
      tick();
      for (int p = 0; p < NP; p++) begin
         req_cmd_in[4*p +: 4]   = 4'd1;
         req_data_in[DW*p +: DW] = 32'h100 * p;
         req_tag_in[TW*p +: TW]  = 2'(p);
      end
      tick();
      req_cmd_in  = '0;
      req_tag_in  = '0;
      req_data_in = {NP{32'h10}};
      tick();
      clear_inputs();
      @(negedge c_clk);
      chk("conc_early", 128'(out_resp), 128'd0);
      for (int p = 0; p < NP; p++) begin
         tick();
         @(negedge c_clk);
         chk("conc_resp", 128'(out_resp), 128'd1 << (2*p));
         chk("conc_data", 128'(out_data), 128'(32'h100 * p + 32'h10) << (DW*p));
         chk("conc_tag", 128'(out_tag), 128'(p) << (TW*p));
      end
      tick();
      @(negedge c_clk);
      chk("conc_late", 128'(out_resp), 128'd0);

      // Backpressure: odd ports run one cycle out of phase with even ports.
      seq = 0;
      rej_cnt = 0;
      pend = '0;
      acc = '0;
      for (int cyc = 0; cyc < 90; cyc++) begin
         tick();
         for (int p = 0; p < NP; p++) begin
            phase = 2'((cyc + p) % 2);
            if (phase == 2'd0) begin
               req_data_in[DW*p +: DW] = '0;
               if (cyc < 40) begin
                  pend_op1[p] = {8'(p), 8'h0, 16'(seq)};
                  pend_tag[p] = 2'(seq);
                  seq++;
                  req_cmd_in[4*p +: 4]    = 4'd1;
                  req_data_in[DW*p +: DW] = pend_op1[p];
                  req_tag_in[TW*p +: TW]  = pend_tag[p];
                  acc[p]  = req_ready[p];
                  pend[p] = 1'b1;
                  if (!acc[p]) rej_cnt++;
               end else begin
                  req_cmd_in[4*p +: 4] = 4'd0;
                  pend[p] = 1'b0;
               end
            end else begin
               req_cmd_in[4*p +: 4]    = 4'd0;
               req_tag_in[TW*p +: TW]  = 2'd0;
               req_data_in[DW*p +: DW] = 32'h3;
               if (pend[p] && acc[p]) expq[p].push_back('{pend_tag[p], pend_op1[p] + 32'h3});
               pend[p] = 1'b0;
            end
         end
         @(negedge c_clk);
         for (int p = 0; p < NP; p++) begin
            r = out_resp[2*p +: 2];
            if (r != 2'd0) begin
               if (expq[p].size() == 0) begin
                  chk("bp_extra_resp", 128'(r), 128'd0);
               end else begin
                  e = expq[p].pop_front();
                  chk("bp_resp", 128'(r), 128'd1);
                  chk("bp_data", 128'(out_data[DW*p +: DW]), 128'(e.data));
                  chk("bp_tag", 128'(out_tag[TW*p +: TW]), 128'(e.tag));
               end
            end
         end
      end
      chk("bp_ready_dropped", 128'(rej_cnt != 0), 128'd1);
      for (int p = 0; p < NP; p++) chk("bp_missing", 128'(expq[p].size()), 128'd0);

      // Reset mid-traffic: outputs clear immediately, nothing stale after release.
      for (int cyc = 0; cyc < 14; cyc++) begin
         tick();
         for (int p = 0; p < NP; p++) begin
            req_cmd_in[4*p +: 4]    = (cyc % 2 == 0) ? 4'd1 : 4'd0;
            req_data_in[DW*p +: DW] = 32'(cyc + p);
            req_tag_in[TW*p +: TW]  = 2'(p);
         end
      end
      @(posedge c_clk);
      #3 reset = 1'b0;
      #1 check_all_idle("rst_async");
      clear_inputs();
      repeat (2) @(posedge c_clk);
      #1 reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge c_clk);
         chk("rst_idle_resp", 128'(out_resp), 128'd0);
         chk("rst_idle_ready", 128'(req_ready), 128'hF);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
